// File: rtl/qspi_flash_writer.sv
// Quad-SPI NAND page programmer: WREN, Quad Program Data Load, Program Execute, then status polling.
// Latency: CS falls one clk after an accepted start; unstalled length 8+24+2N+32+24/poll + gaps + 1 (DONE).
// Backpressure: a one-byte holding register feeds the quad phase; when it is empty at a byte boundary spi_clk is gated with CS held low.
// Ports: start/page_addr/num_bytes launch a sequence; data_in/data_valid/data_ready stream page bytes;
//        spi_clk/spi_cs_n/spi_io_out/spi_io_oe/spi_io form the flash pad interface; busy/done/error report progress.
module qspi_flash_writer #(
  parameter int CS_GAP   = 2,
  parameter int POLL_MAX = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] page_addr,
  input  logic [11:0] num_bytes,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic [3:0]  spi_io_out,
  output logic [3:0]  spi_io_oe,
  input  logic [3:0]  spi_io,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP, S_LOAD_CMD, S_LOAD_DATA, S_EXEC, S_POLL, S_DONE
  } state_t;

  state_t      state_q, state_d, ret_q, ret_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [15:0] page_q, page_d;
  logic [11:0] acc_left_q, acc_left_d, tx_left_q, tx_left_d, poll_q, poll_d;
  logic [7:0]  hold_q, hold_d, stat_q, stat_d;
  logic        hold_full_q, hold_full_d, xmit_q, xmit_d, nib_q, nib_d;
  logic        err_q, err_d, rdy_q, rdy_d;
  logic        accept, bad_len, stall;
  logic [7:0]  status_now;
  logic        unused_io;

  assign unused_io  = ^{spi_io[3:2], spi_io[0]};
  assign accept     = data_valid & rdy_q;
  assign bad_len    = (num_bytes == 12'd0) || (num_bytes > 12'd2048);
  // Status arrives MSB first on IO1; the bit on the pad now completes the byte.
  assign status_now = {stat_q[6:0], spi_io[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      page_q      <= '0;
      acc_left_q  <= '0;
      tx_left_q   <= '0;
      poll_q      <= '0;
      hold_q      <= '0;
      stat_q      <= '0;
      hold_full_q <= 1'b0;
      xmit_q      <= 1'b0;
      nib_q       <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      page_q      <= page_d;
      acc_left_q  <= acc_left_d;
      tx_left_q   <= tx_left_d;
      poll_q      <= poll_d;
      hold_q      <= hold_d;
      stat_q      <= stat_d;
      hold_full_q <= hold_full_d;
      xmit_q      <= xmit_d;
      nib_q       <= nib_d;
      err_q       <= err_d;
      rdy_q       <= rdy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    page_d      = page_q;
    acc_left_d  = acc_left_q;
    tx_left_d   = tx_left_q;
    poll_d      = poll_q;
    hold_d      = hold_q;
    stat_d      = stat_q;
    hold_full_d = hold_full_q;
    xmit_d      = xmit_q;
    nib_d       = nib_q;
    err_d       = err_q;
    rdy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d       = 1'b0;
          page_d      = page_addr;
          acc_left_d  = num_bytes;
          tx_left_d   = num_bytes;
          poll_d      = '0;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          if (bad_len) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WREN;
            sh_d    = {8'h06, 24'h0};
          end
        end
      end
      S_WREN: begin
        sh_d  = {sh_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          state_d = S_GAP;
          ret_d   = S_LOAD_CMD;
          cnt_d   = '0;
          sh_d    = {8'h32, 16'h0000, 8'h00};
        end
      end
      S_GAP: begin
        // The next command was preloaded into sh_q when the gap was entered.
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(CS_GAP - 1)) begin
          state_d = ret_q;
          cnt_d   = '0;
        end
      end
      S_LOAD_CMD: begin
        sh_d  = {sh_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd23) begin
          state_d = S_LOAD_DATA;
          cnt_d   = '0;
          nib_d   = 1'b0;
          xmit_d  = hold_full_q;
          if (hold_full_q) begin
            sh_d        = {hold_q, 24'h0};
            hold_full_d = 1'b0;
          end
        end
      end
      S_LOAD_DATA: begin
        // xmit_q: sh_q[31:24] holds a byte on the wire; nib_q selects its low nibble.
        if (xmit_q && !nib_q) begin
          nib_d = 1'b1;
          sh_d  = {sh_q[27:0], 4'h0};
        end else if (xmit_q) begin
          tx_left_d = tx_left_q - 12'd1;
          nib_d     = 1'b0;
          if (tx_left_q == 12'd1) begin
            state_d = S_GAP;
            ret_d   = S_EXEC;
            cnt_d   = '0;
            xmit_d  = 1'b0;
            sh_d    = {8'h10, 8'h00, page_q};
          end else if (hold_full_q) begin
            sh_d        = {hold_q, 24'h0};
            hold_full_d = 1'b0;
          end else begin
            xmit_d = 1'b0;
          end
        end else if (hold_full_q) begin
          sh_d        = {hold_q, 24'h0};
          hold_full_d = 1'b0;
          xmit_d      = 1'b1;
        end
      end
      S_EXEC: begin
        sh_d  = {sh_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_GAP;
          ret_d   = S_POLL;
          cnt_d   = '0;
          sh_d    = {8'h0F, 8'hC0, 16'h0000};
        end
      end
      S_POLL: begin
        sh_d  = {sh_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q >= 6'd16) stat_d = status_now;
        if (cnt_q == 6'd23) begin
          cnt_d = '0;
          if (!status_now[0]) begin
            state_d = S_DONE;
            err_d   = status_now[3];
          end else if (({1'b0, poll_q} + 13'd1) >= 13'(POLL_MAX)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            poll_d  = poll_q + 12'd1;
            state_d = S_GAP;
            ret_d   = S_POLL;
            sh_d    = {8'h0F, 8'hC0, 16'h0000};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // data_ready only rises when the holding register is empty, so an accept
    // never coincides with a transfer out of it.
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
      acc_left_d  = acc_left_q - 12'd1;
    end

    // Ready is offered during the command header too, so the first byte is
    // already held when the quad phase begins and no stall cycle is needed.
    rdy_d = ((state_d == S_LOAD_CMD) || (state_d == S_LOAD_DATA)) &&
            !hold_full_d && (acc_left_d != 12'd0);
  end

  always_comb begin
    spi_cs_n   = 1'b1;
    spi_io_out = 4'b1100;
    spi_io_oe  = 4'b1101;
    case (state_q)
      S_WREN, S_LOAD_CMD, S_EXEC, S_POLL: begin
        spi_cs_n   = 1'b0;
        spi_io_out = {3'b110, sh_q[31]};
      end
      S_LOAD_DATA: begin
        spi_cs_n   = 1'b0;
        spi_io_out = sh_q[31:28];
        spi_io_oe  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign stall      = (state_q == S_LOAD_DATA) && !xmit_q;
  assign spi_clk    = ~clk & ~spi_cs_n & ~stall;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = err_q;
  assign data_ready = rdy_q;

endmodule

// File: tb/tb_qspi_flash_writer.sv
`timescale 1ns/1ps
module tb_qspi_flash_writer;
  localparam int CS_GAP   = 2;
  localparam int POLL_MAX = 5;
  // Unstalled length with one poll: WREN 8 + gap + LOAD 24+2N + gap + EXEC 32 + gap + POLL 24 + DONE 1.
  localparam int LEN_N4 = 8 + 32 + 32 + 24 + 3*CS_GAP + 1;
  localparam int LEN_N1 = 8 + 26 + 32 + 24 + 3*CS_GAP + 1;
  localparam int POLL_EXTRA = CS_GAP + 24;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] page_addr = '0;
  logic [11:0] num_bytes = '0;
  logic [7:0]  data_in;
  logic        data_valid, data_ready;
  logic        spi_clk, spi_cs_n, busy, done, error;
  logic [3:0]  spi_io_out, spi_io_oe, spi_io;

  qspi_flash_writer #(.CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .page_addr(page_addr), .num_bytes(num_bytes),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe),
    .spi_io(spi_io), .busy(busy), .done(done), .error(error)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records single-bit transactions, quad nibbles, stall and CS-low cycles.
  logic [63:0] txn_val[$];
  int          txn_len[$];
  logic [3:0]  nibs[$];
  int          stall_cycles = 0, cs_low_cycles = 0, poll_txn = 0, bitcnt = 0, cur_len = 0;
  logic [63:0] cur_bits = '0;
  logic        cs_prev = 1'b1;

  initial forever begin
    @(negedge clk); #1;
    if (!spi_cs_n) begin
      cs_low_cycles++;
      if (spi_clk) begin
        if (spi_io_oe == 4'hF) nibs.push_back(spi_io_out);
        else begin cur_bits = {cur_bits[62:0], spi_io_out[0]}; cur_len++; end
        bitcnt++;
      end else stall_cycles++;
    end else if (!cs_prev) begin
      txn_val.push_back(cur_bits);
      txn_len.push_back(cur_len);
      if (cur_len == 24 && cur_bits[23:16] == 8'h0F) poll_txn++;
      cur_bits = '0; cur_len = 0; bitcnt = 0;
    end else bitcnt = 0;
    cs_prev = spi_cs_n;
  end

  // Flash status model: answers BUSY for busy_cfg polls, then fin_status.
  int         busy_cfg = 0, poll_base = 0;
  logic [7:0] fin_status = 8'h00;
  initial begin
    logic [7:0] st;
    spi_io = 4'b0000;
    forever begin
      @(posedge clk); #1;
      if (!spi_cs_n && bitcnt >= 16 && bitcnt < 24) begin
        st = ((poll_txn - poll_base) < busy_cfg) ? 8'h01 : fin_status;
        st = st << (bitcnt - 16);
        spi_io = {2'b00, st[7], 1'b0};
      end else spi_io = 4'b0000;
    end
  end

  // Byte source with an optional hole of feed_hole_len cycles before byte feed_hole_at.
  logic [7:0] feed_dat[0:7];
  int         feed_n = 0, feed_hole_at = 99999, feed_hole_len = 0, fidx = 0, hole_cnt = 0;
  logic       feed_en = 1'b0;
  initial begin
    logic acc;
    data_valid = 1'b0; data_in = '0;
    forever begin
      @(negedge clk);
      acc = data_valid && data_ready;
      @(posedge clk); #1;
      if (!feed_en) begin fidx = 0; hole_cnt = 0; data_valid = 1'b0; end
      else begin
        if (acc) fidx++;
        if (fidx >= feed_n) data_valid = 1'b0;
        else if (fidx == feed_hole_at && hole_cnt < feed_hole_len) begin
          data_valid = 1'b0; hole_cnt++;
        end else begin data_valid = 1'b1; data_in = feed_dat[fidx[2:0]]; end
      end
    end
  end

  task automatic setup_feed(input int n, input logic [31:0] b4, input int hole_at, input int hole_len);
    feed_en = 1'b0;
    feed_n = n; feed_hole_at = hole_at; feed_hole_len = hole_len;
    for (int i = 0; i < 8; i++) feed_dat[i] = b4[31 - 8*(i%4) -: 8];
    repeat (2) @(posedge clk);
    #1 feed_en = 1'b1;
  endtask

  // Returns just after the edge that samples start (first busy cycle).
  task automatic do_start(input logic [15:0] pa, input logic [11:0] nb);
    @(posedge clk); #1;
    start = 1'b1; page_addr = pa; num_bytes = nb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic err);
    logic ok;
    cyc = 1; ok = 1'b0; err = 1'b0;
    while (cyc < budget && !ok) begin
      if (done) begin ok = 1'b1; err = error; end
      else begin @(posedge clk); #1; cyc++; end
    end
    chk("done_within_budget", ok, 1'b1);
  endtask

  initial begin
    int cyc, tb0, nb0, st0, cl0, stl;
    logic err;
    logic [31:0] pk;

    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_cs_n", spi_cs_n, 1'b1);
    chk("rst_spi_clk", spi_clk, 1'b0);
    chk("rst_io_out", spi_io_out, 4'b1100);
    chk("rst_io_oe", spi_io_oe, 4'b1101);
    chk("rst_busy_done_err_rdy", {busy, done, error, data_ready}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;

    // A: N=4, BUSY clears on first poll
    setup_feed(4, 32'hA53C00FF, 99999, 0);
    busy_cfg = 0; fin_status = 8'h00; poll_base = poll_txn;
    tb0 = txn_val.size(); nb0 = nibs.size(); st0 = stall_cycles;
    do_start(16'h1234, 12'd4);
    chk("A_busy_first", busy, 1'b1);
    chk("A_cs_first", spi_cs_n, 1'b0);
    wait_done(2000, cyc, err);
    chk("A_cycles", cyc, LEN_N4);
    chk("A_error", err, 1'b0);
    @(posedge clk); #1;
    chk("A_after_done", {busy, done}, 2'b00);
    chk("A_txn_count", txn_val.size() - tb0, 4);
    chk("A_wren", {txn_val[tb0], 64'(txn_len[tb0])}, {64'h06, 64'd8});
    chk("A_load_hdr", {txn_val[tb0+1], 64'(txn_len[tb0+1])}, {64'h320000, 64'd24});
    chk("A_exec", {txn_val[tb0+2], 64'(txn_len[tb0+2])}, {64'h10001234, 64'd32});
    chk("A_poll", {txn_val[tb0+3], 64'(txn_len[tb0+3])}, {64'h0FC000, 64'd24});
    pk = '0;
    for (int i = 0; i < 8; i++) pk = {pk[27:0], nibs[nb0+i]};
    chk("A_nibbles", {32'(nibs.size() - nb0), pk}, {32'd8, 32'hA53C00FF});
    chk("A_no_stall", stall_cycles - st0, 0);

    // B: data_valid hole before byte 2 stalls the quad phase
    setup_feed(4, 32'hA53C00FF, 2, 5);
    poll_base = poll_txn;
    tb0 = txn_val.size(); nb0 = nibs.size(); st0 = stall_cycles;
    do_start(16'hBEEF, 12'd4);
    wait_done(2000, cyc, err);
    @(posedge clk); #1;
    stl = stall_cycles - st0;
    chk("B_stall_seen", (stl >= 1 && stl <= 5), 1'b1);
    chk("B_cycles", cyc, LEN_N4 + stl);
    chk("B_txn_count", txn_val.size() - tb0, 4);
    chk("B_load_hdr", {txn_val[tb0+1], 64'(txn_len[tb0+1])}, {64'h320000, 64'd24});
    pk = '0;
    for (int i = 0; i < 8; i++) pk = {pk[27:0], nibs[nb0+i]};
    chk("B_nibbles", pk, 32'hA53C00FF);
    chk("B_exec", txn_val[tb0+2], 64'h1000BEEF);

    // C: BUSY for 3 polls
    setup_feed(1, 32'h5A5A5A5A, 99999, 0);
    busy_cfg = 3; poll_base = poll_txn;
    do_start(16'h0001, 12'd1);
    wait_done(2000, cyc, err);
    chk("C_error", err, 1'b0);
    chk("C_cycles", cyc, LEN_N1 + 3*POLL_EXTRA);
    @(posedge clk); #1;
    chk("C_polls", poll_txn - poll_base, 4);

    // D: P-FAIL status 0x08, error held until next start
    setup_feed(1, 32'h11111111, 99999, 0);
    busy_cfg = 0; fin_status = 8'h08; poll_base = poll_txn;
    do_start(16'h0002, 12'd1);
    wait_done(2000, cyc, err);
    chk("D_error", err, 1'b1);
    chk("D_cycles", cyc, LEN_N1);
    repeat (5) @(posedge clk); #1;
    chk("D_error_held", {error, busy}, 2'b10);
    fin_status = 8'h00;
    setup_feed(1, 32'h22222222, 99999, 0);
    do_start(16'h0003, 12'd1);
    chk("D_error_cleared", error, 1'b0);
    wait_done(2000, cyc, err);
    chk("D2_error", err, 1'b0);

    // Poll timeout: flash stays busy, POLL_MAX polls then error
    setup_feed(1, 32'h33333333, 99999, 0);
    busy_cfg = 1000; poll_base = poll_txn;
    do_start(16'h0004, 12'd1);
    wait_done(2000, cyc, err);
    chk("T_error", err, 1'b1);
    chk("T_cycles", cyc, LEN_N1 + (POLL_MAX-1)*POLL_EXTRA);
    @(posedge clk); #1;
    chk("T_polls", poll_txn - poll_base, POLL_MAX);
    busy_cfg = 0;

    // E: illegal lengths 0 and 2049, no CS activity
    cl0 = cs_low_cycles;
    do_start(16'h0005, 12'd0);
    wait_done(10, cyc, err);
    chk("E0_latency", (cyc >= 1 && cyc <= 2), 1'b1);
    chk("E0_error", err, 1'b1);
    do_start(16'h0006, 12'd2049);
    wait_done(10, cyc, err);
    chk("E2049_error", err, 1'b1);
    @(posedge clk); #1;
    chk("E_no_cs", cs_low_cycles - cl0, 0);

    // Full page of 2048 bytes is legal and runs unstalled
    setup_feed(2048, 32'hDEADBEEF, 99999, 0);
    st0 = stall_cycles;
    do_start(16'h0007, 12'd2048);
    wait_done(6000, cyc, err);
    chk("P2048_error", err, 1'b0);
    chk("P2048_cycles", cyc, 8 + 24 + 4096 + 32 + 24 + 3*CS_GAP + 1);
    chk("P2048_no_stall", stall_cycles - st0, 0);

    // F: asynchronous reset mid LOAD_DATA, then a clean run
    setup_feed(4, 32'hA53C00FF, 99999, 0);
    do_start(16'h0008, 12'd4);
    cyc = 0;
    while (spi_io_oe != 4'hF && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("F_reached_load_data", spi_io_oe, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("F_rst_cs_n", spi_cs_n, 1'b1);
    chk("F_rst_spi_clk", spi_clk, 1'b0);
    chk("F_rst_io", {spi_io_out, spi_io_oe}, {4'b1100, 4'b1101});
    chk("F_rst_flags", {busy, done, error, data_ready}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    setup_feed(4, 32'hA53C00FF, 99999, 0);
    poll_base = poll_txn;
    nb0 = nibs.size();
    do_start(16'h0009, 12'd4);
    wait_done(2000, cyc, err);
    chk("F_cycles", cyc, LEN_N4);
    chk("F_error", err, 1'b0);
    @(posedge clk); #1;
    pk = '0;
    for (int i = 0; i < 8; i++) pk = {pk[27:0], nibs[nb0+i]};
    chk("F_nibbles", pk, 32'hA53C00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qspi_flash_writer.md
# qspi_flash_writer

Quad-SPI NAND page programmer, the write-direction counterpart of the video player's flash read FSM. It accepts a byte stream over a valid/ready handshake and issues Write Enable (0x06), then Quad Program Data Load (0x32) into the flash page buffer. It follows with Program Execute (0x10) to a 16-bit page address and polls Status Register-3 (0x0F/0xC0) until BUSY clears. It drives the same SPI pins as the reader; a top-level mux selects which block owns the bus.

## Interface
- `CS_GAP`, 2: clk cycles `spi_cs_n` is held high between commands (≥1).
- `POLL_MAX`, 4095: status polls before timeout error.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a program sequence. Ignored while `busy`=1.
- `page_addr` in 16: page address, latched on accepted `start`.
- `num_bytes` in 12: byte count, latched on accepted `start`. Legal range is 1..2048.
- `data_in` in 8: program byte.
- `data_valid` in 1: `data_in` valid.
- `data_ready` out 1: byte accepted on a clk rise when `data_valid`=1 and `data_ready`=1.
- `spi_clk` out 1: `~clk` while CS is low and not stalled, else 0.
- `spi_cs_n` out 1: flash chip select.
- `spi_io_out` out 4: IO3..IO0 output values.
- `spi_io_oe` out 4: per-pin output enable (1 = drive).
- `spi_io` in 4: IO3..IO0 pad inputs.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid with `done`. Held until the next accepted `start`.

## Operation
- Reset values:
  - `spi_cs_n`=1, `spi_clk`=0.
  - `spi_io_out`=4'b1100 (HOLD#/WP# high), `spi_io_oe`=4'b1101.
  - `busy`, `done`, `error`, `data_ready` = 0.
  - State is IDLE.
- Reset asserted mid-sequence: CS rises asynchronously and any partial program is abandoned.
- States: IDLE → WREN → GAP → LOAD_CMD → LOAD_DATA → GAP → EXEC → GAP → POLL → (GAP → POLL)* → DONE → IDLE. GAP holds CS high for `CS_GAP` cycles, then enters the stored next state.
- Accepted `start` with `num_bytes`=0 or >2048: go directly to DONE with `error`=1. No CS activity.
- Single-bit phases:
  - Data goes MSB first on IO0. IO3 and IO2 are driven 1; IO1 is an input.
  - WREN sends 8 bits (0x06).
  - LOAD_CMD sends 24 bits: 0x32 followed by column 0x0000.
  - EXEC sends 32 bits: 0x10, 8 dummy bits of 0, then `page_addr`.
- LOAD_DATA (quad phase):
  - `spi_io_oe`=4'b1111. Each byte takes 2 SPI cycles, high nibble first, on IO3..IO0.
  - One-byte holding register. `data_ready`=1 in LOAD_DATA while the holding register is empty and bytes remain.
  - If the register is empty at a byte boundary, gate `spi_clk` to 0 and keep CS low (stall). Resume on the cycle after acceptance.
  - `data_ready` drops once the last byte has been accepted.
- POLL:
  - Send 16 bits (0x0F, 0xC0) on IO0, then read 8 bits from IO1 with IO0 driving 0.
  - Status bit order is MSB first. bit0 = BUSY, bit3 = P-FAIL.
  - BUSY=1: take GAP then POLL again, and increment the poll counter.
  - Poll counter reaches `POLL_MAX` with BUSY still 1: go to DONE with `error`=1.
  - BUSY=0: go to DONE with `error` = P-FAIL.
- DONE: `done`=1 for one cycle, `busy`=0 on the following cycle. `start` is accepted again from that cycle.

## Timing
- Output values change on clk rise; the flash samples on `spi_clk` rise (clk fall).
- A status bit driven by the flash during SPI cycle n is sampled on the clk rise that ends cycle n.
- `start` seen on clk edge k: `busy`=1 and `spi_cs_n`=0 from edge k+1, with the first WREN bit on IO0.
- Unstalled sequence length, N = `num_bytes`, polls P ≥ 1:
  - WREN 8, LOAD 24+2N, EXEC 32, each poll 24.
  - Plus `CS_GAP` before LOAD, before EXEC, before POLL, and between polls.
  - Plus 1 cycle for DONE.
- `spi_cs_n` returns high on the clk edge after the last bit of each command.
- `data_ready` is registered. A byte accepted at edge j is driven no earlier than SPI cycle j+1.

## Test plan
- N=4, bytes 0xA5,0x3C,0x00,0xFF, `page_addr`=0x1234, flash model BUSY clears on first poll → bus trace exactly matches:
  - 0x06 / 0x32 0000 / nibbles A,5,3,C,0,0,F,F / 0x10 00 1234 / 0x0F C0.
  - `done` pulse with `error`=0. Total 8+32+32+24+3·`CS_GAP`+1 cycles.
- `data_valid` low for 5 cycles before byte 2 → `spi_clk` flat 0 for those cycles, CS stays low, and the nibble sequence is unbroken.
- Model reports BUSY for 3 polls → 4 POLL transactions separated by `CS_GAP`-high gaps, then `done` with `error`=0.
- Model returns status 0x08 → `done` with `error`=1. `error` stays 1 until the next `start`.
- `num_bytes`=0 → `done` pulse 1–2 cycles after `start` with `error`=1. `spi_cs_n` never goes low.
- `rst_n` pulsed low mid LOAD_DATA → `spi_cs_n`=1 immediately (asynchronous), all outputs at reset values. A new `start` then completes normally.
